// File: rtl/ram_sp_arbiter.sv
// Round-robin arbiter for two requesters sharing one single-port RAM.
// Runs a full-depth init sweep after reset, then serves A and B and routes read data back.
module ram_sp_arbiter #(
    parameter int MEM_WIDTH  = 16,
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_SIZE  = 10,
    parameter int RD_LATENCY = 2,
    parameter logic [MEM_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [MEM_WIDTH-1:0] a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [MEM_WIDTH-1:0] a_rdata,
    output logic                 a_rparity,

    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [MEM_WIDTH-1:0] b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [MEM_WIDTH-1:0] b_rdata,
    output logic                 b_rparity,

    output logic                 init_done,

    output logic                 ram_blk_select,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic                 ram_addr_en,
    output logic                 ram_dout_en,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [MEM_WIDTH-1:0] ram_din,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    input  logic                 ram_parity
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    localparam logic [ADDR_SIZE-1:0] INIT_LAST = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [0:0]            r_state;
    logic [ADDR_SIZE-1:0]  r_init_cnt;
    logic                  r_init_done;
    logic                  r_last_grant;
    logic [RD_LATENCY-1:0] r_rd_vld_pipe;
    logic [RD_LATENCY-1:0] r_rd_id_pipe;

    logic w_run;
    logic w_init;
    logic w_gnt_a;
    logic w_gnt_b;
    logic w_rd_accept;
    logic w_rd_id;
    logic w_ret_vld;
    logic w_ret_id;

    // Outputs are gated by rst so every control pin shows its idle value while reset is held.
    assign w_init = (r_state == ST_INIT) && !rst;
    assign w_run  = (r_state == ST_RUN)  && !rst;

    // On a tie, the requester that did not win last time takes the slot.
    assign w_gnt_a = w_run && a_req && (!b_req || (r_last_grant == ID_B));
    assign w_gnt_b = w_run && b_req && (!a_req || (r_last_grant == ID_A));

    assign w_rd_accept = (w_gnt_a && !a_we) || (w_gnt_b && !b_we);
    assign w_rd_id     = w_gnt_b ? ID_B : ID_A;

    assign w_ret_vld = r_rd_vld_pipe[RD_LATENCY-1] && !rst;
    assign w_ret_id  = r_rd_id_pipe[RD_LATENCY-1];

    always_comb begin
        ram_blk_select = 1'b0;
        ram_wr_en      = 1'b0;
        ram_rd_en      = 1'b0;
        ram_addr       = '0;
        ram_din        = '0;
        if (w_init) begin
            ram_blk_select = 1'b1;
            ram_wr_en      = 1'b1;
            ram_addr       = r_init_cnt;
            ram_din        = INIT_VALUE;
        end else if (w_gnt_a) begin
            ram_blk_select = 1'b1;
            ram_wr_en      = a_we;
            ram_rd_en      = !a_we;
            ram_addr       = a_addr;
            ram_din        = a_wdata;
        end else if (w_gnt_b) begin
            ram_blk_select = 1'b1;
            ram_wr_en      = b_we;
            ram_rd_en      = !b_we;
            ram_addr       = b_addr;
            ram_din        = b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_init_cnt   <= '0;
            r_init_done  <= 1'b0;
            r_last_grant <= ID_B;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == INIT_LAST) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    if (w_gnt_a) begin
                        r_last_grant <= ID_A;
                    end else if (w_gnt_b) begin
                        r_last_grant <= ID_B;
                    end
                end
            endcase
        end
    end

    // Read-return tracker: one slot per cycle of RAM latency; valid is cleared by reset, id is not.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld_pipe <= '0;
        end else begin
            r_rd_vld_pipe[0] <= w_rd_accept;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_vld_pipe[i] <= r_rd_vld_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_rd_id_pipe[0] <= w_rd_id;
        for (int i = 1; i < RD_LATENCY; i++) begin
            r_rd_id_pipe[i] <= r_rd_id_pipe[i-1];
        end
    end

    assign a_gnt     = w_gnt_a;
    assign b_gnt     = w_gnt_b;
    assign a_rvalid  = w_ret_vld && (w_ret_id == ID_A);
    assign b_rvalid  = w_ret_vld && (w_ret_id == ID_B);
    assign a_rdata   = ram_dout;
    assign b_rdata   = ram_dout;
    assign a_rparity = ram_parity;
    assign b_rparity = ram_parity;
    assign init_done = r_init_done && !rst;

    assign ram_addr_en = 1'b0;
    assign ram_dout_en = 1'b1;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Directed bench for ram_sp_arbiter with a small depth and a behavioural 2-cycle RAM.
`timescale 1ns/1ps
module tb_ram_sp_arbiter;

    localparam int MW = 16;
    localparam int MD = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [MW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, a_rparity, b_gnt, b_rvalid, b_rparity;
    logic [MW-1:0] a_rdata, b_rdata;
    logic          init_done;
    logic          ram_blk_select, ram_wr_en, ram_rd_en, ram_addr_en, ram_dout_en;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_din, ram_dout;
    logic          ram_parity;

    int n_asserts = 0;
    int n_fail    = 0;

    ram_sp_arbiter #(
        .MEM_WIDTH(MW), .MEM_DEPTH(MD), .ADDR_SIZE(AW), .RD_LATENCY(2), .INIT_VALUE(16'h0000)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_rparity(a_rparity),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_rparity(b_rparity),
        .init_done(init_done),
        .ram_blk_select(ram_blk_select), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
        .ram_addr_en(ram_addr_en), .ram_dout_en(ram_dout_en),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .ram_parity(ram_parity)
    );

    always #5 clk = ~clk;

    // RAM model: no address register, registered output -> data two cycles after the address.
    logic [MW-1:0] mem [MD];
    logic [MW-1:0] ram_q1;
    always @(posedge clk) begin
        if (ram_blk_select && ram_wr_en) mem[ram_addr] <= ram_din;
        if (ram_blk_select && ram_rd_en) ram_q1 <= mem[ram_addr];
        if (ram_dout_en) ram_dout <= ram_q1;
    end
    assign ram_parity = ^ram_dout;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        @(negedge clk);
        step();
        step();

        // Reset values
        #1;
        check("rst_init_done", init_done, 0);
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_blk_sel", ram_blk_select, 0);
        check("rst_wr_en", ram_wr_en, 0);
        check("rst_rd_en", ram_rd_en, 0);
        check("rst_addr_en", ram_addr_en, 0);
        check("rst_dout_en", ram_dout_en, 1);

        // Release reset with B already requesting a read of addr 5
        @(negedge clk);
        rst = 1'b0;
        b_req = 1; b_we = 0; b_addr = 4'd5;
        for (int i = 0; i < MD; i++) begin
            #1;
            check("init_b_gnt", b_gnt, 0);
            check("init_a_gnt", a_gnt, 0);
            check("init_done_low", init_done, 0);
            check("init_wr_en", ram_wr_en, 1);
            check("init_addr", ram_addr, i);
            check("init_din", ram_din, 0);
            step();
        end
        #1;
        check("init_done_rise", init_done, 1);
        check("first_run_b_gnt", b_gnt, 1);
        check("first_run_rd_en", ram_rd_en, 1);
        check("first_run_addr", ram_addr, 5);
        step();
        b_req = 0;
        #1;
        check("b_rd5_c1_rvalid", b_rvalid, 0);
        step();
        check("b_rd5_rvalid", b_rvalid, 1);
        check("b_rd5_rdata", b_rdata, 16'h0000);
        check("b_rd5_a_rvalid", a_rvalid, 0);
        step();
        check("b_rd5_rvalid_off", b_rvalid, 0);

        // A writes 0x1234 to addr 3, then reads it back
        a_req = 1; a_we = 1; a_addr = 4'd3; a_wdata = 16'h1234;
        #1;
        check("a_wr_gnt", a_gnt, 1);
        check("a_wr_wr_en", ram_wr_en, 1);
        check("a_wr_rd_en", ram_rd_en, 0);
        check("a_wr_din", ram_din, 16'h1234);
        step();
        a_we = 0;
        #1;
        check("a_rd_gnt", a_gnt, 1);
        check("a_rd_rd_en", ram_rd_en, 1);
        step();
        a_req = 0;
        #1;
        check("a_rd3_c1_rvalid", a_rvalid, 0);
        step();
        check("a_rd3_rvalid", a_rvalid, 1);
        check("a_rd3_rdata", a_rdata, 16'h1234);
        check("a_rd3_rparity", a_rparity, 1);
        check("a_rd3_b_rvalid", b_rvalid, 0);
        step();
        check("a_rd3_rvalid_off", a_rvalid, 0);
        check("a_rd3_b_rvalid_off", b_rvalid, 0);

        // Preload addr 7 (by A) and addr 8 (by B); leaves B as last winner
        a_req = 1; a_we = 1; a_addr = 4'd7; a_wdata = 16'h00FF;
        #1;
        check("pre_a_gnt", a_gnt, 1);
        step();
        a_req = 0;
        b_req = 1; b_we = 1; b_addr = 4'd8; b_wdata = 16'h0F00;
        #1;
        check("pre_b_gnt", b_gnt, 1);
        step();

        // Both request writes continuously: grants alternate starting with A
        a_req = 1; a_we = 1; a_addr = 4'd10; a_wdata = 16'hAAAA;
        b_req = 1; b_we = 1; b_addr = 4'd11; b_wdata = 16'h5555;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_a_gnt", a_gnt, (i % 2 == 0) ? 1 : 0);
            check("rr_b_gnt", b_gnt, (i % 2 == 0) ? 0 : 1);
            check("rr_addr", ram_addr, (i % 2 == 0) ? 10 : 11);
            step();
        end
        a_req = 0; b_req = 0;

        // B reads 7, then A reads 8 the next cycle
        b_req = 1; b_we = 0; b_addr = 4'd7;
        #1;
        check("seq_b_gnt", b_gnt, 1);
        step();
        b_req = 0;
        a_req = 1; a_we = 0; a_addr = 4'd8;
        #1;
        check("seq_a_gnt", a_gnt, 1);
        check("seq_c1_b_rvalid", b_rvalid, 0);
        step();
        a_req = 0;
        #1;
        check("seq_b_rvalid", b_rvalid, 1);
        check("seq_b_rdata", b_rdata, 16'h00FF);
        check("seq_b_rparity", b_rparity, 0);
        check("seq_a_rvalid_early", a_rvalid, 0);
        step();
        check("seq_a_rvalid", a_rvalid, 1);
        check("seq_a_rdata", a_rdata, 16'h0F00);
        check("seq_b_rvalid_off", b_rvalid, 0);
        step();
        check("seq_a_rvalid_off", a_rvalid, 0);

        // A read granted, then reset next cycle: read is dropped and init reruns
        a_req = 1; a_we = 0; a_addr = 4'd3;
        #1;
        check("rst_mid_a_gnt", a_gnt, 1);
        step();
        a_req = 0;
        rst = 1'b1;
        #1;
        check("rst_mid_blk_sel", ram_blk_select, 0);
        check("rst_mid_a_rvalid", a_rvalid, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < MD; i++) begin
            #1;
            check("reinit_a_rvalid", a_rvalid, 0);
            check("reinit_done_low", init_done, 0);
            check("reinit_wr_en", ram_wr_en, 1);
            check("reinit_addr", ram_addr, i);
            step();
        end
        #1;
        check("reinit_done", init_done, 1);

        // Addr 3 was swept back to the init value
        a_req = 1; a_we = 0; a_addr = 4'd3;
        #1;
        check("post_a_gnt", a_gnt, 1);
        step();
        a_req = 0;
        step();
        check("post_a_rvalid", a_rvalid, 1);
        check("post_a_rdata", a_rdata, 16'h0000);
        check("post_a_rparity", a_rparity, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sp_arbiter.md
Name: ram_sp_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port RAM instance.
- After reset it runs an init sweep that writes INIT_VALUE to every address, then serves requester A and requester B.
- For each granted read it returns rdata, rparity and a one-cycle rvalid to the requester that issued it, RD_LATENCY cycles after acceptance.
- It sits between two client blocks and the RAM. It owns all RAM control pins.

Parameters:
- MEM_WIDTH, 16: data width; must equal the RAM width.
- MEM_DEPTH, 1024: number of words; the init sweep covers 0..MEM_DEPTH-1.
- ADDR_SIZE, 10: address width.
- RD_LATENCY, 2: cycles from the acceptance cycle to the rvalid cycle. The RAM runs with address pipeline off and output pipeline on, which gives 2. Legal range 1..4.
- INIT_VALUE, 0: word written during the init sweep.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- a_req  in  1  requester A wants an access
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_SIZE  A address
- a_wdata  in  MEM_WIDTH  A write data
- a_gnt  out  1  A request accepted this cycle
- a_rvalid  out  1  A read data valid
- a_rdata  out  MEM_WIDTH  A read data
- a_rparity  out  1  A read parity
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_rparity: same as A, for requester B
- init_done  out  1  init sweep complete
- ram_blk_select  out  1  RAM block select
- ram_wr_en  out  1  RAM write enable
- ram_rd_en  out  1  RAM read enable
- ram_addr_en  out  1  RAM address-register enable; tied 0
- ram_dout_en  out  1  RAM output-register enable; tied 1
- ram_addr  out  ADDR_SIZE  RAM address
- ram_din  out  MEM_WIDTH  RAM write data
- ram_dout  in  MEM_WIDTH  RAM read data
- ram_parity  in  1  RAM parity of ram_dout

Behaviour:
- FSM states: INIT and RUN. Reset forces INIT, init counter = 0, last_grant = B (so A wins the first tie), in-flight pipeline cleared.
- Reset values: a_gnt, b_gnt, a_rvalid, b_rvalid and init_done are 0. All ram_* control pins are 0 except ram_dout_en = 1.
- INIT state:
  - Each cycle: ram_blk_select = 1, ram_wr_en = 1, ram_addr = counter, ram_din = INIT_VALUE; counter increments.
  - When the cycle with counter = MEM_DEPTH-1 completes, go to RUN and set init_done = 1 (registered).
  - Init therefore takes exactly MEM_DEPTH cycles. Both gnt outputs stay 0 throughout; requests are not lost.
- RUN state, arbitration (combinational, same cycle):
  - Only A requests: grant A. Only B requests: grant B.
  - Both request: grant the requester not recorded in last_grant.
  - last_grant updates on every grant.
  - At most one gnt per cycle; gnt is never asserted without the matching req.
- RUN state, RAM drive (combinational mux of the granted requester):
  - ram_blk_select = 1, ram_addr = addr, ram_din = wdata.
  - ram_wr_en = we; ram_rd_en = !we.
  - With no grant: blk_select, wr_en and rd_en are 0.
- Requester handshake: hold req, we, addr and wdata stable until gnt is seen. The transfer happens in the cycle where req and gnt are both 1. A requester may drop req only after its gnt.
- Read return:
  - A RD_LATENCY-deep shift register carries {valid, id} for each accepted read.
  - Read accepted in cycle C: x_rvalid = 1 in cycle C+RD_LATENCY only, where x is the issuing requester.
  - a_rdata and b_rdata both mirror ram_dout; a_rparity and b_rparity both mirror ram_parity. Sample them only while the matching rvalid is high.
  - Back-to-back reads give back-to-back rvalids in issue order.
- Writes: no response. A read of the same address in any later cycle returns the new data.
- Reset mid-operation: in-flight reads are dropped (no rvalid), the FSM returns to INIT and the full sweep reruns.

Test Plan:
- Reset, MEM_DEPTH=16: no gnt for 16 cycles; init_done rises at cycle 16; reading addr 5 returns 0x0000 with rvalid 2 cycles after gnt.
- A writes 0x1234 to addr 3, then A reads addr 3: a_rvalid for exactly one cycle at C+2, a_rdata = 0x1234, a_rparity = 1; b_rvalid stays 0.
- A and B request continuously for 6 cycles: grants alternate A,B,A,B,A,B; never both in one cycle.
- B reads addr 7 (holding 0x00FF), then A reads addr 8 (holding 0x0F00) in the next cycle: b_rvalid with 0x00FF, then a_rvalid with 0x0F00 one cycle later.
- A is granted a read, and rst is asserted the next cycle: no a_rvalid is ever produced; init_done = 0 and the init sweep reruns.
- B requests during INIT: b_gnt stays 0 until the first RUN cycle, then b_gnt = 1 with no other request present.
